// File: rtl/hoene_led_pwm_multi_pkg.sv
// Shared helpers for the multi-channel LED PWM: period length, per-channel
// stagger offsets and the legal parameter ranges.
package hoene_led_pkg;

  localparam int MIN_CHANNELS = 1;
  localparam int MAX_CHANNELS = 8;
  localparam int MIN_WIDTH    = 2;
  localparam int MAX_WIDTH    = 12;

  // PWM period in ticks; one short of 2^width so that the all-ones duty word
  // is high for every tick.
  function automatic int period_of(input int width);
    return (1 << width) - 1;
  endfunction

  // Stagger offset of channel idx, spreading channels evenly over the period.
  function automatic int off(input int idx, input int channels, input int period);
    return (idx * period) / channels;
  endfunction

  // True when the parameter set is one the generator supports.
  function automatic bit params_ok(input int channels, input int width, input int prescale);
    return (channels >= MIN_CHANNELS) && (channels <= MAX_CHANNELS) &&
           (width >= MIN_WIDTH) && (width <= MAX_WIDTH) && (prescale >= 1);
  endfunction

endpackage

// File: rtl/hoene_led_pwm_multi_if.sv
// Duty-word handshake between the protocol layer (master) and the PWM block
// (slave). One beat carries the duty words of every channel.
interface hoene_led_pwm_multi_if #(
  parameter int CHANNELS = 3,
  parameter int WIDTH    = 10
);
  logic [CHANNELS*WIDTH-1:0] in_data;
  logic                      in_valid;
  logic                      in_ready;

  modport master (output in_data, output in_valid, input in_ready);
  modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/hoene_led_pwm_multi_channel.sv
// One PWM channel: shifts the shared tick count by this channel's offset,
// wraps it into the period and compares against the active duty word.
// Fed with the counter/duty values the top is about to register, so the
// registered output lines up with the counter state it describes.
module hoene_pwm_channel
  import hoene_led_pkg::*;
#(
  parameter int WIDTH  = 10,
  parameter int OFFSET = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stagger_i,
  input  logic [WIDTH-1:0] cnt_i,
  input  logic [WIDTH-1:0] active_i,
  output logic             pwm_o
);

  localparam int             P       = period_of(WIDTH);
  localparam logic [WIDTH:0] OFF_W   = (WIDTH+1)'(OFFSET);
  localparam logic [WIDTH:0] PERIOD_W = (WIDTH+1)'(P);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] ph;
  logic           pwm_d;
  logic           pwm_q;

  // Phase of this channel within the period and the resulting output level.
  always_comb begin
    sum   = {1'b0, cnt_i} + (stagger_i ? OFF_W : '0);
    ph    = (sum >= PERIOD_W) ? (sum - PERIOD_W) : sum;
    pwm_d = (ph < {1'b0, active_i});
  end

  // Registered output, forced low in reset.
  always_ff @(posedge clk) begin
    if (rst) pwm_q <= 1'b0;
    else     pwm_q <= pwm_d;
  end

  assign pwm_o = pwm_q;

endmodule

// File: rtl/hoene_led_pwm_multi.sv
// Multi-channel PWM generator. Holds the prescaler, the shared tick counter
// and the double-buffered duty words (shadow accepted over the handshake,
// active used by the channels). Shadow moves to active only on the last tick
// of a period, so every period is generated from a single duty set.
module hoene_led_pwm_multi
  import hoene_led_pkg::*;
#(
  parameter int CHANNELS = 3,
  parameter int WIDTH    = 10,
  parameter int PRESCALE = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  hoene_led_pwm_multi_if.slave   bus,
  input  logic                   stagger,
  output logic [CHANNELS-1:0]    out_pwm,
  output logic                   period_start
);

  localparam int               P        = period_of(WIDTH);
  localparam int               PRE_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);
  localparam logic [WIDTH-1:0] CNT_LAST = WIDTH'(P - 1);

  if (!params_ok(CHANNELS, WIDTH, PRESCALE)) begin : g_param_check
    $error("hoene_led_pwm_multi: unsupported CHANNELS/WIDTH/PRESCALE");
  end

  logic [PRE_W-1:0]          pre_q, pre_d;
  logic [WIDTH-1:0]          cnt_q, cnt_d;
  logic [CHANNELS*WIDTH-1:0] shadow_q, shadow_d;
  logic [CHANNELS*WIDTH-1:0] active_q, active_d;
  logic                      pending_q, pending_d;
  logic                      ps_q, ps_d;
  logic                      tick;
  logic                      boundary;
  logic                      accept;

  assign tick     = (pre_q == PRE_LAST);
  assign boundary = tick && (cnt_q == CNT_LAST);
  assign accept   = bus.in_valid && !pending_q;

  // Next state of timing base and duty buffers. A pending update always wins
  // the boundary; a capture on a boundary with nothing pending waits a period.
  always_comb begin
    pre_d     = tick ? '0 : pre_q + PRE_W'(1);
    cnt_d     = cnt_q;
    if (tick) cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + WIDTH'(1);
    shadow_d  = shadow_q;
    active_d  = active_q;
    pending_d = pending_q;
    if (boundary && pending_q) begin
      active_d  = shadow_q;
      pending_d = 1'b0;
    end else if (accept) begin
      shadow_d  = bus.in_data;
      pending_d = 1'b1;
    end
    ps_d = boundary;
  end

  // State registers; reset aborts the period and drops any pending update.
  always_ff @(posedge clk) begin
    if (rst) begin
      pre_q     <= '0;
      cnt_q     <= '0;
      shadow_q  <= '0;
      active_q  <= '0;
      pending_q <= 1'b0;
      ps_q      <= 1'b0;
    end else begin
      pre_q     <= pre_d;
      cnt_q     <= cnt_d;
      shadow_q  <= shadow_d;
      active_q  <= active_d;
      pending_q <= pending_d;
      ps_q      <= ps_d;
    end
  end

  assign bus.in_ready = !pending_q;
  assign period_start = ps_q;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    hoene_pwm_channel #(
      .WIDTH  (WIDTH),
      .OFFSET (off(i, CHANNELS, P))
    ) u_ch (
      .clk       (clk),
      .rst       (rst),
      .stagger_i (stagger),
      .cnt_i     (cnt_d),
      .active_i  (active_d[i*WIDTH +: WIDTH]),
      .pwm_o     (out_pwm[i])
    );
  end

endmodule

// File: tb/tb_hoene_led_pwm_multi.sv
// Bench for hoene_led_pwm_multi: two instances (PRESCALE 1 and 4) share one
// stimulus stream and are compared every cycle against a cycle-count model.
module tb_hoene_led_pwm_multi;

  localparam int CH = 3;
  localparam int W  = 4;
  localparam int P  = (1 << W) - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst;
  logic            stagger;
  logic            vld;
  logic [CH*W-1:0] din;
  logic [CH-1:0]   pwm1, pwm4;
  logic            ps1, ps4;

  hoene_led_pwm_multi_if #(.CHANNELS(CH), .WIDTH(W)) if1 ();
  hoene_led_pwm_multi_if #(.CHANNELS(CH), .WIDTH(W)) if4 ();

  assign if1.in_data  = din;
  assign if1.in_valid = vld;
  assign if4.in_data  = din;
  assign if4.in_valid = vld;

  hoene_led_pwm_multi #(.CHANNELS(CH), .WIDTH(W), .PRESCALE(1)) dut1 (
    .clk(clk), .rst(rst), .bus(if1), .stagger(stagger),
    .out_pwm(pwm1), .period_start(ps1));

  hoene_led_pwm_multi #(.CHANNELS(CH), .WIDTH(W), .PRESCALE(4)) dut4 (
    .clk(clk), .rst(rst), .bus(if4), .stagger(stagger),
    .out_pwm(pwm4), .period_start(ps4));

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs != exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0d expected %0d", tag, $time, obs, exp);
    end
  endtask

  // Reference model: cycles since reset, applied and held duty sets.
  int pre_of[2] = '{1, 4};
  int mt[2];
  int mact[2][CH];
  int msh[2][CH];
  bit mpend[2];
  bit mstg;

  function automatic int exp_out(input int d);
    int r = 0;
    int tp = (mt[d] / pre_of[d]) % P;
    for (int i = 0; i < CH; i++) begin
      int ph = (tp + (mstg ? (i * P) / CH : 0)) % P;
      if (ph < mact[d][i]) r |= (1 << i);
    end
    return r;
  endfunction

  function automatic int exp_ps(input int d);
    return (mt[d] > 0 && (mt[d] % (P * pre_of[d])) == 0) ? 1 : 0;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      mt[d] = 0; mpend[d] = 1'b0;
      for (int i = 0; i < CH; i++) begin mact[d][i] = 0; msh[d][i] = 0; end
    end
  endtask

  task automatic check_all();
    chk("pwm_p1", int'(pwm1), exp_out(0));
    chk("ps_p1",  int'(ps1),  exp_ps(0));
    chk("rdy_p1", int'(if1.in_ready), mpend[0] ? 0 : 1);
    chk("pwm_p4", int'(pwm4), exp_out(1));
    chk("ps_p4",  int'(ps4),  exp_ps(1));
    chk("rdy_p4", int'(if4.in_ready), mpend[1] ? 0 : 1);
  endtask

  // One clock: check at negedge, drive, advance the model at posedge.
  task automatic step(input bit r, input bit v, input logic [CH*W-1:0] d, input bit s);
    check_all();
    rst = r; vld = v; din = d; stagger = s;
    @(posedge clk);
    if (r) model_reset();
    else begin
      for (int k = 0; k < 2; k++) begin
        bit bnd = (mt[k] % (P * pre_of[k])) == (P * pre_of[k] - 1);
        if (bnd && mpend[k]) begin
          for (int i = 0; i < CH; i++) mact[k][i] = msh[k][i];
          mpend[k] = 1'b0;
        end else if (v && !mpend[k]) begin
          for (int i = 0; i < CH; i++) msh[k][i] = int'(d[i*W +: W]);
          mpend[k] = 1'b1;
        end
        mt[k]++;
      end
    end
    mstg = s;
    @(negedge clk);
  endtask

  task automatic idle(input int n, input bit s);
    repeat (n) step(1'b0, 1'b0, '0, s);
  endtask

  function automatic logic [CH*W-1:0] pack(input int d2, input int d1, input int d0);
    return {W'(d2), W'(d1), W'(d0)};
  endfunction

  function automatic int rnd_duty();
    case ($urandom % 4)
      0:       return 0;
      1:       return P;
      default: return int'($urandom_range(0, P));
    endcase
  endfunction

  initial begin
    int gap, hi;
    bit s;
    rst = 1'b1; vld = 1'b0; din = '0; stagger = 1'b0; mstg = 1'b0;
    model_reset();
    @(posedge clk); @(negedge clk);
    repeat (3) step(1'b1, 1'b0, '0, 1'b0);
    idle(32, 1'b0);

    // aligned load {15,7,0}
    step(1'b0, 1'b1, pack(15, 7, 0), 1'b0);
    idle(130, 1'b0);

    // staggered, all channels duty 5
    step(1'b0, 1'b1, pack(5, 5, 5), 1'b1);
    idle(130, 1'b1);

    // back-to-back: A=3s then B=9s held while not ready
    step(1'b0, 1'b1, pack(3, 3, 3), 1'b0);
    repeat (70) step(1'b0, 1'b1, pack(9, 9, 9), 1'b0);
    idle(130, 1'b0);

    // capture exactly on the boundary tick of the fast instance
    for (int k = 0; k < 40; k++) begin
      if ((mt[0] % P) == P - 1) break;
      idle(1, 1'b0);
    end
    chk("bnd_align", mt[0] % P, P - 1);
    step(1'b0, 1'b1, pack(11, 2, 13), 1'b0);
    idle(130, 1'b0);

    // randomized traffic, stagger toggles and occasional resets
    s = 1'b0;
    for (int k = 0; k < 700; k++) begin
      if ($urandom % 60 == 0) s = ~s;
      step(($urandom % 250) == 0, ($urandom % 4) == 0,
           pack(rnd_duty(), rnd_duty(), rnd_duty()), s);
    end
    idle(130, 1'b0);

    // prescaled instance, duty 1 on every channel
    step(1'b0, 1'b1, pack(1, 1, 1), 1'b0);
    idle(130, 1'b0);
    for (int k = 0; k < 80; k++) begin
      if (ps4) break;
      idle(1, 1'b0);
    end
    chk("p4_ps_found", int'(ps4), 1);
    hi = int'(pwm4[0]);
    gap = 0;
    for (int k = 0; k < 100; k++) begin
      idle(1, 1'b0);
      gap++;
      if (ps4) break;
      hi += int'(pwm4[0]);
    end
    chk("p4_spacing", gap, 60);
    chk("p4_high", hi, 4);

    // mid-period reset with an update pending
    idle(20, 1'b0);
    step(1'b0, 1'b1, pack(9, 9, 9), 1'b0);
    idle(3, 1'b0);
    chk("p4_pend_before_rst", int'(if4.in_ready), 0);
    step(1'b1, 1'b0, '0, 1'b0);
    step(1'b1, 1'b0, '0, 1'b0);
    idle(2, 1'b0);
    chk("p4_rst_pwm", int'(pwm4), 0);
    chk("p4_rst_rdy", int'(if4.in_ready), 1);
    idle(130, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
